// File: rtl/mac_stream_if.sv
// Handshake and configuration bundle for mac_stream: operand streams, result stream, config and status.
interface mac_stream_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 8
);
    logic              config_en;
    logic              signed_mode;
    logic              sat_en;
    logic [CNT_W-1:0]  data_num;
    logic [DATA_W-1:0] in_a;
    logic              in_valid_a;
    logic              in_ready_a;
    logic [DATA_W-1:0] in_b;
    logic              in_valid_b;
    logic              in_ready_b;
    logic [OUT_W-1:0]  mac_out;
    logic              out_valid;
    logic              out_ready;
    logic              ovf_flag;
    logic              busy;

    modport slave (
        input  config_en, signed_mode, sat_en, data_num,
        input  in_a, in_valid_a, in_b, in_valid_b, out_ready,
        output in_ready_a, in_ready_b, mac_out, out_valid, ovf_flag, busy
    );

    modport master (
        output config_en, signed_mode, sat_en, data_num,
        output in_a, in_valid_a, in_b, in_valid_b, out_ready,
        input  in_ready_a, in_ready_b, mac_out, out_valid, ovf_flag, busy
    );
endinterface

// File: rtl/mac_stream.sv
// Streaming multiply-accumulate: two buffered operand streams, data_num products per group,
// optional saturation of the result, auto-restart after each accepted result.
module mac_stream_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + (AW+1)'(1);
            if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

module mac_stream #(
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 16,
    parameter int ACC_W      = 40,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    mac_stream_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_e;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, num_q, num_d;
    logic                signed_q, signed_d, sat_q, sat_d;

    logic [DATA_W-1:0]   a_dout, b_dout;
    logic                a_full, a_empty, b_full, b_empty;
    logic                pop, handshake, load_cfg;
    logic [CNT_W-1:0]    cnt_inc;
    logic signed [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [ACC_W-1:0]    prod_ext;

    assign bus.in_ready_a = !a_full;
    assign bus.in_ready_b = !b_full;

    mac_stream_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk(clk), .rst_n(rst_n),
        .push_i(bus.in_valid_a && !a_full), .din_i(bus.in_a),
        .pop_i(pop), .dout_o(a_dout), .full_o(a_full), .empty_o(a_empty)
    );

    mac_stream_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk(clk), .rst_n(rst_n),
        .push_i(bus.in_valid_b && !b_full), .din_i(bus.in_b),
        .pop_i(pop), .dout_o(b_dout), .full_o(b_full), .empty_o(b_empty)
    );

    assign pop       = (state_q == S_ACC) && !a_empty && !b_empty;
    assign handshake = (state_q == S_OUT) && bus.out_ready;
    assign load_cfg  = bus.config_en && (bus.data_num != '0) && ((state_q == S_IDLE) || handshake);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Full-precision product, extended to the accumulator width according to the operand mode.
    assign prod_s   = $signed(a_dout) * $signed(b_dout);
    assign prod_u   = a_dout * b_dout;
    assign prod_ext = signed_q ? ACC_W'(prod_s) : ACC_W'(prod_u);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (load_cfg) state_d = S_ACC;
            S_ACC:  if (pop && (cnt_inc == num_q)) state_d = S_OUT;
            S_OUT:  if (bus.out_ready) state_d = (bus.config_en && bus.data_num == '0) ? S_IDLE : S_ACC;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        signed_d = signed_q;
        sat_d    = sat_q;
        if (load_cfg) begin
            num_d    = bus.data_num;
            signed_d = bus.signed_mode;
            sat_d    = bus.sat_en;
        end
        if (load_cfg || handshake) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (pop) begin
            acc_d = acc_q + prod_ext;
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            num_q    <= CNT_W'(1);
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            signed_q <= signed_d;
            sat_q    <= sat_d;
        end
    end

    // Result is derived from the held accumulator, so it stays stable for the whole OUT state.
    always_comb begin
        bus.mac_out   = '0;
        bus.ovf_flag  = 1'b0;
        bus.out_valid = (state_q == S_OUT);
        bus.busy      = (state_q != S_IDLE);
        if (state_q == S_OUT) begin
            bus.mac_out = acc_q[OUT_W-1:0];
            if (sat_q && signed_q) begin
                if (!(&acc_q[ACC_W-1:OUT_W-1] || !(|acc_q[ACC_W-1:OUT_W-1]))) begin
                    bus.mac_out  = acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
                    bus.ovf_flag = 1'b1;
                end
            end else if (sat_q) begin
                if (|acc_q[ACC_W-1:OUT_W]) begin
                    bus.mac_out  = '1;
                    bus.ovf_flag = 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_stream.sv
// Directed bench for mac_stream: stimulus pushes expected results into a queue,
// an independent monitor pops and compares on every accepted output.
module tb_mac_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mac_stream_if #(.DATA_W(16), .OUT_W(16), .CNT_W(8)) bus ();

    mac_stream #(.DATA_W(16), .OUT_W(16), .ACC_W(40), .CNT_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [15:0] mac;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic expect_result(input logic [15:0] mac, input logic ovf);
        exp_t e;
        e.mac = mac;
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // Monitor: compares on each handshake and checks the result holds while stalled.
    initial begin
        exp_t        e;
        logic        stall = 1'b0;
        logic [15:0] prev_mac = '0;
        logic        prev_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall)
                    check("hold_while_stalled", {bus.out_valid, bus.ovf_flag, bus.mac_out},
                          {1'b1, prev_ovf, prev_mac});
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output_queue_size", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("mac_out", bus.mac_out, e.mac);
                        check("ovf_flag", bus.ovf_flag, e.ovf);
                    end
                end
                stall    = bus.out_valid && !bus.out_ready;
                prev_mac = bus.mac_out;
                prev_ovf = bus.ovf_flag;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.config_en   = 1'b0;
        bus.signed_mode = 1'b0;
        bus.sat_en      = 1'b0;
        bus.data_num    = '0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.in_valid_a  = 1'b0;
        bus.in_valid_b  = 1'b0;
        bus.out_ready   = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic configure(input logic sgn, input logic sat, input logic [7:0] n);
        bus.config_en   = 1'b1;
        bus.signed_mode = sgn;
        bus.sat_en      = sat;
        bus.data_num    = n;
        tick();
        bus.config_en   = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input bit do_a, input bit do_b);
        bit pend_a = do_a;
        bit pend_b = do_b;
        bit ok_a, ok_b;
        int n = 0;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_valid_a = pend_a;
        bus.in_valid_b = pend_b;
        while ((pend_a || pend_b) && n < 50) begin
            @(negedge clk);
            ok_a = pend_a && bus.in_ready_a;
            ok_b = pend_b && bus.in_ready_b;
            tick();
            if (ok_a) pend_a = 1'b0;
            if (ok_b) pend_b = 1'b0;
            bus.in_valid_a = pend_a;
            bus.in_valid_b = pend_b;
            n++;
        end
        check("push_accepted", {pend_a, pend_b}, 0);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mac_ovf", {bus.mac_out, bus.ovf_flag}, 0);
        check("rst_ready_ab", {bus.in_ready_a, bus.in_ready_b}, 2'b11);
        tick();
        rst_n = 1'b1;
        tick();

        // Lockstep signed group of 4, exact latency, then data_num=0 in the handshake cycle.
        configure(1'b1, 1'b0, 8'd4);
        expect_result(16'd70, 1'b0);
        push(16'd1, 16'd5, 1, 1);
        push(16'd2, 16'd6, 1, 1);
        push(16'd3, 16'd7, 1, 1);
        push(16'd4, 16'd8, 1, 1);
        @(negedge clk);
        check("valid_before_last_pop", bus.out_valid, 0);
        tick();
        bus.config_en = 1'b1;
        bus.data_num  = 8'd0;
        @(negedge clk);
        check("valid_after_last_pop", bus.out_valid, 1);
        tick();
        bus.config_en = 1'b0;
        @(negedge clk);
        check("cfg0_handshake_to_idle", bus.busy, 0);
        drain("drain_lockstep", 5);

        // data_num=0 in IDLE ignored; A arrives early; config during ACC ignored.
        bus.config_en = 1'b1;
        bus.data_num  = 8'd0;
        tick();
        bus.config_en = 1'b0;
        @(negedge clk);
        check("cfg0_idle_ignored", bus.busy, 0);
        tick();
        configure(1'b0, 1'b0, 8'd2);
        expect_result(16'd12, 1'b0);
        push(16'd2, 16'd0, 1, 0);
        push(16'd2, 16'd0, 1, 0);
        bus.config_en = 1'b1;
        bus.data_num  = 8'd3;
        tick();
        bus.config_en = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("a_waits_for_b", {bus.busy, bus.out_valid}, 2'b10);
        tick();
        push(16'd0, 16'd3, 0, 1);
        push(16'd0, 16'd3, 0, 1);
        drain("drain_a_early", 20);

        // Signed saturation, both directions, plus an in-range negative result (auto-restart).
        do_reset();
        configure(1'b1, 1'b1, 8'd2);
        expect_result(16'h7FFF, 1'b1);
        push(16'h7FFF, 16'h7FFF, 1, 1);
        push(16'h7FFF, 16'h7FFF, 1, 1);
        drain("drain_sat_pos", 20);
        expect_result(16'h8000, 1'b1);
        push(16'h8000, 16'h0002, 1, 1);
        push(16'h0000, 16'h0000, 1, 1);
        drain("drain_sat_neg", 20);
        expect_result(16'hFFFA, 1'b0);
        push(16'hFFFE, 16'h0003, 1, 1);
        push(16'h0000, 16'h0005, 1, 1);
        drain("drain_signed_neg", 20);

        // Unsigned wrap and unsigned saturation.
        do_reset();
        configure(1'b0, 1'b0, 8'd1);
        expect_result(16'h0001, 1'b0);
        push(16'hFFFF, 16'hFFFF, 1, 1);
        drain("drain_unsigned_wrap", 20);
        do_reset();
        configure(1'b0, 1'b1, 8'd1);
        expect_result(16'hFFFF, 1'b1);
        push(16'hFFFF, 16'hFFFF, 1, 1);
        drain("drain_unsigned_sat", 20);
        expect_result(16'h000C, 1'b0);
        push(16'h0003, 16'h0004, 1, 1);
        drain("drain_unsigned_small", 20);

        // Back-pressure: result held, FIFOs fill, then queued groups complete.
        do_reset();
        configure(1'b1, 1'b0, 8'd2);
        bus.out_ready = 1'b0;
        expect_result(16'd5, 1'b0);
        expect_result(16'd25, 1'b0);
        expect_result(16'd61, 1'b0);
        for (int i = 1; i <= 6; i++) push(16'(i), 16'(i), 1, 1);
        @(negedge clk);
        check("fifos_full_ready_low", {bus.in_ready_a, bus.in_ready_b, bus.out_valid}, 3'b001);
        tick();
        repeat (3) tick();
        bus.out_ready = 1'b1;
        drain("drain_backpressure", 40);

        // Reset after two of four pops with a third pair still queued.
        do_reset();
        configure(1'b0, 1'b0, 8'd4);
        push(16'd1, 16'd1, 1, 1);
        push(16'd2, 16'd2, 1, 1);
        push(16'd3, 16'd3, 1, 1);
        rst_n = 1'b0;
        #2;
        check("midreset_outputs", {bus.out_valid, bus.busy, bus.in_ready_a, bus.in_ready_b}, 4'b0011);
        tick();
        rst_n = 1'b1;
        tick();
        configure(1'b0, 1'b0, 8'd4);
        expect_result(16'd10, 1'b0);
        push(16'd1, 16'd1, 1, 1);
        push(16'd2, 16'd1, 1, 1);
        push(16'd3, 16'd1, 1, 1);
        push(16'd4, 16'd1, 1, 1);
        drain("drain_after_reset", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
